// File: rtl/branch_pkg.sv
// Shared types for the branch resolution stage: opcodes, ALU flag layout
// and the condition evaluator.
package branch_pkg;

    localparam int FLAG_W = 4;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_JMP  = 4'd1,
        OP_BEQ  = 4'd2,
        OP_BNE  = 4'd3,
        OP_BLT  = 4'd4,
        OP_BGE  = 4'd5,
        OP_BCS  = 4'd6,
        OP_BCC  = 4'd7,
        OP_CALL = 4'd8,
        OP_RET  = 4'd9
    } br_op_t;

    typedef struct packed {
        logic v;
        logic c;
        logic n;
        logic z;
    } flags_t;

    // Only the conditional branches are decided here; JMP/CALL/RET are handled by the caller.
    function automatic logic cond_met(br_op_t op, flags_t f);
        logic met;
        met = 1'b0;
        case (op)
            OP_BEQ:  met = f.z;
            OP_BNE:  met = ~f.z;
            OP_BLT:  met = f.n ^ f.v;
            OP_BGE:  met = ~(f.n ^ f.v);
            OP_BCS:  met = f.c;
            OP_BCC:  met = ~f.c;
            default: met = 1'b0;
        endcase
        return met;
    endfunction

endpackage

// File: rtl/branch_ctrl_unit_ras.sv
// Circular return-address stack: a push while full overwrites the oldest entry,
// a pop while empty is dropped. Both cases latch a sticky error bit.
module ras_stack #(
    parameter int ADDR_W    = 10,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] push_data_i,
    output logic [ADDR_W-1:0] top_o,
    output logic              empty_o,
    output logic              ovf_o,
    output logic              unf_o
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              full;

    assign full    = (count_q == CNT_W'(RAS_DEPTH));
    assign empty_o = (count_q == '0);
    assign top_o   = mem_q[wr_ptr_q - PTR_W'(1)];
    assign ovf_o   = ovf_q;
    assign unf_o   = unf_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (full) ovf_d = 1'b1;
            else      count_d = count_q + CNT_W'(1);
        end else if (pop_i) begin
            if (empty_o) begin
                unf_d = 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q - PTR_W'(1);
                count_d  = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage needs no reset: count_q gates every read.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/branch_ctrl_unit.sv
// Registered branch resolution: decodes the op, redirects the PC one cycle later
// and holds flush_o for FLUSH_CYCLES cycles after every taken redirect.
//
// state | meaning
// IDLE  | accepting branch ops
// FLUSH | younger stages flushed, inputs ignored
module branch_ctrl_unit
    import branch_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int RAS_DEPTH    = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic [3:0]        op_i,
    input  logic              jenable_i,
    input  logic [FLAG_W-1:0] flags_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [ADDR_W-1:0] target_i,
    output logic              taken_o,
    output logic [ADDR_W-1:0] target_o,
    output logic              flush_o,
    output logic              ras_ovf_o,
    output logic              ras_unf_o
);
    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} fl_state_t;

    fl_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              taken_q, taken_d;
    logic [ADDR_W-1:0] target_q, target_d;

    br_op_t            op;
    logic              accept, take, push, pop;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_empty;

    assign op     = br_op_t'(op_i);
    assign accept = valid_i & jenable_i & (state_q == IDLE);
    assign push   = accept & (op == OP_CALL);
    assign pop    = accept & (op == OP_RET);

    always_comb begin
        take     = 1'b0;
        target_d = target_q;
        case (op)
            OP_JMP, OP_CALL: take = 1'b1;
            OP_RET:          take = ~ras_empty;
            default:         take = cond_met(op, flags_t'(flags_i));
        endcase
        take    = take & accept;
        taken_d = take;
        if (take) target_d = (op == OP_RET) ? ras_top : target_i;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (take) begin
                state_d = FLUSH;
                cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
            end
            FLUSH: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            taken_q  <= 1'b0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            taken_q  <= taken_d;
            target_q <= target_d;
        end
    end

    ras_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (pc_i + ADDR_W'(1)),
        .top_o       (ras_top),
        .empty_o     (ras_empty),
        .ovf_o       (ras_ovf_o),
        .unf_o       (ras_unf_o)
    );

    assign taken_o  = taken_q;
    assign target_o = target_q;
    assign flush_o  = (state_q == FLUSH);

endmodule

// File: tb/tb_branch_ctrl_unit.sv
// Directed bench for branch_ctrl_unit with hand-computed expectations.
module tb_branch_ctrl_unit;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid_i;
    logic [3:0] op_i;
    logic       jenable_i;
    logic [3:0] flags_i;
    logic [9:0] pc_i;
    logic [9:0] target_i;
    logic       taken_o;
    logic [9:0] target_o;
    logic       flush_o;
    logic       ras_ovf_o;
    logic       ras_unf_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_ctrl_unit #(.ADDR_W(10), .RAS_DEPTH(4), .FLUSH_CYCLES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_i   (valid_i),
        .op_i      (op_i),
        .jenable_i (jenable_i),
        .flags_i   (flags_i),
        .pc_i      (pc_i),
        .target_i  (target_i),
        .taken_o   (taken_o),
        .target_o  (target_o),
        .flush_o   (flush_o),
        .ras_ovf_o (ras_ovf_o),
        .ras_unf_o (ras_unf_o)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [3:0] fl,
                         input logic [9:0] pc, input logic [9:0] tgt);
        valid_i = 1'b1; jenable_i = 1'b1; op_i = op; flags_i = fl; pc_i = pc; target_i = tgt;
        tick();
        valid_i = 1'b0;
    endtask

    task automatic idle2();
        valid_i = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        // junk inputs during reset
        rst_n = 1'b0; valid_i = 1'b1; op_i = 4'd1; jenable_i = 1'b1;
        flags_i = 4'hF; pc_i = 10'd77; target_i = 10'd123;
        tick(); tick();
        check("rst_taken", taken_o, 0);
        check("rst_target", target_o, 0);
        check("rst_flush", flush_o, 0);
        check("rst_ovf", ras_ovf_o, 0);
        check("rst_unf", ras_unf_o, 0);
        rst_n = 1'b1;

        issue(4'd0, 4'h0, 10'd0, 10'd9);
        check("nop_taken", taken_o, 0);
        issue(4'd12, 4'hF, 10'd0, 10'd9);
        check("op12_taken", taken_o, 0);

        // BEQ Z=1 -> taken, 2-cycle flush
        issue(4'd2, 4'b0001, 10'd0, 10'd25);
        check("beq_taken", taken_o, 1);
        check("beq_target", target_o, 25);
        check("beq_flush1", flush_o, 1);
        tick();
        check("beq_pulse", taken_o, 0);
        check("beq_flush2", flush_o, 1);
        tick();
        check("beq_flush_end", flush_o, 0);

        issue(4'd3, 4'b0001, 10'd0, 10'd30);
        check("bne_taken", taken_o, 0);
        check("bne_flush", flush_o, 0);
        check("bne_target_hold", target_o, 25);

        issue(4'd6, 4'b0000, 10'd0, 10'd40);
        check("bcs_taken", taken_o, 0);
        issue(4'd5, 4'b1010, 10'd0, 10'd45);
        check("bge_nv_taken", taken_o, 1);
        check("bge_target", target_o, 45);
        idle2();

        // BLT N=1 V=0, then JMP during flush is ignored
        issue(4'd4, 4'b0010, 10'd0, 10'd65);
        check("blt_taken", taken_o, 1);
        check("blt_target", target_o, 65);
        issue(4'd1, 4'b0000, 10'd0, 10'd60);
        check("jmp_in_flush_taken", taken_o, 0);
        check("jmp_in_flush_flush", flush_o, 1);
        tick();
        check("flush_done", flush_o, 0);
        check("flush_done_taken", taken_o, 0);
        tick();
        check("no_second_flush", flush_o, 0);
        check("target_after_ignore", target_o, 65);

        valid_i = 1'b1; jenable_i = 1'b0; op_i = 4'd1; target_i = 10'd60;
        tick();
        check("jen0_taken", taken_o, 0);
        check("jen0_flush", flush_o, 0);
        valid_i = 1'b0; jenable_i = 1'b1;

        // CALL / RET / RET on empty
        issue(4'd8, 4'h0, 10'd100, 10'd200);
        check("call_taken", taken_o, 1);
        check("call_target", target_o, 200);
        idle2();
        issue(4'd9, 4'h0, 10'd0, 10'd0);
        check("ret_taken", taken_o, 1);
        check("ret_target", target_o, 101);
        idle2();
        issue(4'd9, 4'h0, 10'd0, 10'd0);
        check("ret_empty_taken", taken_o, 0);
        check("ret_empty_flush", flush_o, 0);
        check("ret_empty_unf", ras_unf_o, 1);
        tick();
        check("unf_sticky", ras_unf_o, 1);

        rst_n = 1'b0; tick(); rst_n = 1'b1;
        check("rst2_unf", ras_unf_o, 0);

        // Overflow: five CALLs into a four-deep stack
        for (int i = 1; i <= 5; i++) begin
            issue(4'd8, 4'h0, 10'(i * 10), 10'(500 + i));
            check("ovf_call_taken", taken_o, 1);
            check("ovf_call_target", target_o, 500 + i);
            check("ovf_flag", ras_ovf_o, (i == 5) ? 1 : 0);
            idle2();
        end
        for (int i = 0; i < 4; i++) begin
            issue(4'd9, 4'h0, 10'd0, 10'd0);
            check("ovf_ret_taken", taken_o, 1);
            check("ovf_ret_target", target_o, 51 - 10 * i);
            idle2();
        end
        check("unf_before_5th", ras_unf_o, 0);
        issue(4'd9, 4'h0, 10'd0, 10'd0);
        check("ret5_taken", taken_o, 0);
        check("ret5_unf", ras_unf_o, 1);
        check("ovf_sticky", ras_ovf_o, 1);

        rst_n = 1'b0; tick(); rst_n = 1'b1;

        // PC wrap, then reset mid-flush clears flush and RAS
        issue(4'd8, 4'h0, 10'd1023, 10'd7);
        check("wrap_call_target", target_o, 7);
        idle2();
        issue(4'd9, 4'h0, 10'd0, 10'd0);
        check("wrap_ret_taken", taken_o, 1);
        check("wrap_ret_target", target_o, 0);
        idle2();
        issue(4'd8, 4'h0, 10'd300, 10'd400);
        check("pre_rst_flush", flush_o, 1);
        rst_n = 1'b0;
        tick();
        check("midflush_rst_flush", flush_o, 0);
        check("midflush_rst_taken", taken_o, 0);
        rst_n = 1'b1;
        issue(4'd9, 4'h0, 10'd0, 10'd0);
        check("post_rst_ret_taken", taken_o, 0);
        check("post_rst_ret_unf", ras_unf_o, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_ctrl_unit.md
Name:
branch_ctrl_unit

Overview:
Parametrised successor of the combinational branch unit: a registered branch-resolution stage. It evaluates a wider condition set against Z/N/C/V flags and supports CALL/RET through an internal return-address stack (RAS). When a redirect is taken, it drives a multi-cycle pipeline flush. It sits between decode/execute and the PC register, and its redirect outputs feed the PC mux and the fetch/decode flush lines.

Parameters:
ADDR_W, 10, PC/target address width
RAS_DEPTH, 4, return-address stack entries (power of 2, >=2)
FLUSH_CYCLES, 2, cycles flush_o stays high after a taken redirect (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous reset, active-low
valid_i  in  1  instruction in this stage is valid
op_i  in  4  branch opcode (encoding below)
jenable_i  in  1  global branch enable; 0 turns every op into NOP
flags_i  in  4  {V,C,N,Z} from ALU
pc_i  in  ADDR_W  PC of the current instruction
target_i  in  ADDR_W  absolute branch target
taken_o  out  1  registered: redirect taken this cycle
target_o  out  ADDR_W  registered redirect address; valid only when taken_o=1
flush_o  out  1  flush younger pipeline stages
ras_ovf_o  out  1  sticky: push while RAS full
ras_unf_o  out  1  sticky: RET while RAS empty

Behaviour:
- Reset (rst_n=0 at a clk edge): taken_o=0, target_o=0, flush_o=0, ras_ovf_o=0, ras_unf_o=0, RAS count=0, flush counter=0. Reset mid-flush aborts the flush immediately.
- Opcodes: 0 NOP, 1 JMP, 2 BEQ(Z), 3 BNE(!Z), 4 BLT(N^V), 5 BGE(!(N^V)), 6 BCS(C), 7 BCC(!C), 8 CALL, 9 RET, 10-15 NOP.
- An op is accepted when valid_i=1, jenable_i=1 and flush_o=0. Inputs seen while flush_o=1 are ignored; no RAS change occurs.
- Latency: 1 cycle. Condition evaluation happens at edge k, and taken_o/target_o are valid during cycle k+1. taken_o is a 1-cycle pulse.
- Target selection: JMP and conditional ops use target_i. CALL uses target_i and pushes (pc_i+1) mod 2^ADDR_W. RET pops the top entry and redirects to it.
- RAS is circular, with a top pointer and a count that saturates at RAS_DEPTH.
  - Push while full overwrites the oldest entry, keeps count=RAS_DEPTH, and sets ras_ovf_o.
  - RET while empty gives taken_o=0, no pointer change, and sets ras_unf_o.
- Sticky error bits clear only on reset.
- Flush FSM states are IDLE and FLUSH.
  - IDLE->FLUSH on an accepted taken op. flush_o rises in the same cycle as taken_o.
  - The counter loads FLUSH_CYCLES-1 and decrements each cycle in FLUSH. FLUSH->IDLE when the counter reaches 0.
  - flush_o stays high for exactly FLUSH_CYCLES cycles.
- Not-taken conditional: taken_o=0, flush_o=0, target_o holds its previous value.
- PC wrap: pc_i=2^ADDR_W-1 pushes 0.

Decomposition:
- Package branch_pkg holds:
  - typedef enum logic [3:0] br_op_t (the op codes above)
  - typedef struct flags_t {V,C,N,Z}
  - localparam FLAG_W=4
  - function cond_met(br_op_t, flags_t), which is pure combinational
- Sub-module ras_stack (params ADDR_W, RAS_DEPTH) contains push/pop/full/empty and overflow handling. The top level holds the decode, flush FSM and output registers.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with junk inputs -> all outputs 0. Release; a NOP gives taken_o=0.
- Conditionals (ADDR_W=10, FLUSH_CYCLES=2):
  - BEQ, target 25, Z=1 -> next cycle taken_o=1, target_o=25, flush_o high for 2 cycles.
  - BNE, target 30, Z=1 -> taken_o=0, flush_o=0.
  - BLT, target 65, N=1, V=0 -> taken.
- jenable gating: JMP, target 60, jenable_i=0 -> no redirect. JMP issued during flush_o=1 -> ignored, and no second flush follows.
- CALL/RET: CALL pc=100, target=200 -> redirect to 200. After the flush, RET -> redirect to 101. A second RET -> taken_o=0, ras_unf_o=1.
- RAS overflow (RAS_DEPTH=4): 5 CALLs with pc=10,20,30,40,50 -> ras_ovf_o=1. RETs then return 51,41,31,21, and the 5th RET sets ras_unf_o.
- Wrap/reset: CALL pc=1023 then RET -> target_o=0. Assert rst_n=0 during flush -> flush_o=0 on the next cycle and RAS empty.
